vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_counter.sv | 83 ++++++++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, pattern mode encodings and
// the colour-bar palette helper.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    // Bar index bits map straight onto full-scale R, G and B (3-3-2 packing).
    function automatic logic [7:0] bar_colour(input logic [2:0] idx);
        return {{3{idx[2]}}, {3{idx[1]}}, {2{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Horizontal/vertical raster counters and registered sync/active/position
// decode; every output lags the counters by exactly one pixel tick.
module vga_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    output logic [X_W-1:0] h_cnt,
    output logic [Y_W-1:0] v_cnt,
    output logic           line_end,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic           frame_start,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0] H_ACT      = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_SYNC_ON  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] H_SYNC_OFF = X_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0] V_ACT      = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_SYNC_ON  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] V_SYNC_OFF = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic hs_band;
    logic vs_band;
    logic visible;

    assign line_end = (h_cnt == H_LAST);

    always_comb begin
        hs_band = (h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF);
        vs_band = (v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF);
        visible = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
            end else begin
                h_cnt <= h_cnt + X_W'(1);
            end
            // Outputs capture the position being left, giving the fixed one-tick lag.
            x           <= h_cnt;
            y           <= v_cnt;
            hsync       <= hs_band ? HS_POL : ~HS_POL;
            vsync       <= vs_band ? VS_POL : ~VS_POL;
            active      <= visible;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with a built-in test-pattern source (solid, colour
// bars, checkerboard, gradient) aligned to the registered timing outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    input  logic [1:0]     mode,
    input  logic [7:0]     solid_rgb,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           frame_start,
    output logic [2:0]     vga_red,
    output logic [2:0]     vga_green,
    output logic [1:0]     vga_blue
);

    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] BAR_LAST = X_W'(H_ACTIVE / 8 - 1);

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           line_end;

    mode_e          mode_q;
    mode_e          mode_eff;
    logic           frame_origin;
    logic [X_W-1:0] bar_px;
    logic [2:0]     bar_idx;
    logic [7:0]     pix_next;
    logic [7:0]     rgb;

    vga_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .line_end    (line_end),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_start (frame_start),
        .x           (x),
        .y           (y)
    );

    // At the frame origin the incoming mode is used directly so the very first
    // pixel of a frame already shows the newly selected pattern.
    always_comb begin
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
        mode_eff     = frame_origin ? mode_e'(mode) : mode_q;
        pix_next     = 8'h00;
        if ((h_cnt < H_ACT) && (v_cnt < V_ACT)) begin
            case (mode_eff)
                MODE_SOLID:    pix_next = solid_rgb;
                MODE_BARS:     pix_next = bar_colour(bar_idx);
                MODE_CHECKER:  pix_next = (h_cnt[5] ^ v_cnt[5]) ? 8'hFF : 8'h00;
                MODE_GRADIENT: pix_next = h_cnt[7:0];
                default:       pix_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_SOLID;
            bar_px  <= '0;
            bar_idx <= '0;
            rgb     <= 8'h00;
        end else if (pix_en) begin
            if (frame_origin) begin
                mode_q <= mode_e'(mode);
            end
            // Bar position tracks h_cnt by counting pixels, avoiding a divider.
            if (line_end) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + X_W'(1);
            end
            rgb <= pix_next;
        end
    end

    assign vga_red   = rgb[7:5];
    assign vga_green = rgb[4:2];
    assign vga_blue  = rgb[1:0];

endmodule
